// File: rtl/uart_rx_if.sv
// Parallel-side bundle of the UART receiver: serial line in, recovered byte
// and status strobes out, plus the FSM state for observation.
//
// Handshake: rx_valid is a single-cycle qualifier for rx_data with no
// backpressure (there is no ready). The consumer must take rx_data in the
// cycle rx_valid is high. rx_data keeps its value afterwards until the next
// good frame. frame_err is a single-cycle strobe and is never high together
// with rx_valid.
interface uart_rx_if #(
  parameter int BIT_MAX = 8
);
  logic               rx;
  logic [BIT_MAX-1:0] rx_data;
  logic               rx_valid;
  logic               frame_err;
  logic               busy;
  logic [1:0]         state;

  // Receiver side: samples the line and drives the parallel outputs.
  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy,
    output state
  );

  // Line driver and byte consumer side.
  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy,
    input  state
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver. The line is synchronised, a falling edge arms the FSM,
// the start bit is confirmed at mid-bit, and data bits are then sampled at
// bit centres LSB first. A good stop bit publishes the byte with a one-cycle
// rx_valid. A low stop bit gives a one-cycle frame_err and leaves rx_data
// untouched. A held-low line (break) re-arms only on a new high-to-low edge.
module uart_rx #(
  parameter int BPS_MAX = 5208,
  parameter int BIT_MAX = 8
) (
  input  logic   clk,
  input  logic   rst,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(BPS_MAX);
  localparam int BW = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [CW-1:0] HALF_LAST = CW'(BPS_MAX / 2 - 1);
  localparam logic [CW-1:0] FULL_LAST = CW'(BPS_MAX - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_MAX - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic               rx_s1, rx_s2, rx_s3;
  logic               fall;
  logic [CW-1:0]      bps_cnt, bps_cnt_nxt;
  logic [BW-1:0]      bit_cnt, bit_cnt_nxt;
  logic [BIT_MAX-1:0] shift, shift_nxt;
  logic [BIT_MAX-1:0] data_q, data_nxt;
  logic               valid_q, valid_nxt;
  logic               err_q, err_nxt;

  // Two-flop synchroniser plus a history flop for edge detection. All three
  // reset high so that an idle line shows no edge when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_s3 <= 1'b1;
    end else begin
      rx_s1 <= bus.rx;
      rx_s2 <= rx_s1;
      rx_s3 <= rx_s2;
    end
  end

  assign fall = rx_s3 & ~rx_s2;

  // State, counters, shift register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      bps_cnt <= '0;
      bit_cnt <= '0;
      shift   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      bps_cnt <= bps_cnt_nxt;
      bit_cnt <= bit_cnt_nxt;
      shift   <= shift_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  // Next-state logic. Edges matter only in IDLE. Every other state is paced
  // by bps_cnt alone.
  always_comb begin
    state_nxt   = state;
    bps_cnt_nxt = bps_cnt;
    bit_cnt_nxt = bit_cnt;
    shift_nxt   = shift;
    data_nxt    = data_q;
    valid_nxt   = 1'b0;
    err_nxt     = 1'b0;
    case (state)
      IDLE: begin
        bps_cnt_nxt = '0;
        bit_cnt_nxt = '0;
        if (fall) begin
          state_nxt = START;
        end
      end
      START: begin
        if (bps_cnt == HALF_LAST) begin
          bps_cnt_nxt = '0;
          // A line that is high again at mid-bit was a glitch.
          state_nxt   = rx_s2 ? IDLE : DATA;
        end else begin
          bps_cnt_nxt = bps_cnt + 1'b1;
        end
      end
      DATA: begin
        if (bps_cnt == FULL_LAST) begin
          bps_cnt_nxt        = '0;
          shift_nxt[bit_cnt] = rx_s2;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_nxt = '0;
            state_nxt   = STOP;
          end else begin
            bit_cnt_nxt = bit_cnt + 1'b1;
          end
        end else begin
          bps_cnt_nxt = bps_cnt + 1'b1;
        end
      end
      STOP: begin
        if (bps_cnt == FULL_LAST) begin
          bps_cnt_nxt = '0;
          state_nxt   = IDLE;
          if (rx_s2) begin
            data_nxt  = shift;
            valid_nxt = 1'b1;
          end else begin
            err_nxt   = 1'b1;
          end
        end else begin
          bps_cnt_nxt = bps_cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state != IDLE);
  assign bus.state     = state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. One instance runs at 16 clk/bit for the
// functional cases. A second instance runs at the default 5208 clk/bit for
// the latency check at the real baud divisor.
module tb_uart_rx;

  localparam int BPS   = 16;
  localparam int BPS_D = 5208;
  localparam int W     = 8;

  // Clock and reset.
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if #(.BIT_MAX(W)) bus_a ();
  uart_rx_if #(.BIT_MAX(W)) bus_b ();

  uart_rx #(.BPS_MAX(BPS), .BIT_MAX(W)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (bus_a)
  );

  uart_rx #(.BPS_MAX(BPS_D), .BIT_MAX(W)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (bus_b)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  int unsigned cyc      = 0;

  logic [W-1:0] exp_q[$];
  logic [W-1:0] got_a[$];
  int unsigned  got_t_a[$];
  logic [W-1:0] got_b[$];
  int unsigned  got_t_b[$];
  int           fe_a = 0;
  int           fe_b = 0;
  int           busy_cnt_a = 0;
  int           overlap = 0;

  int unsigned  t0;
  int unsigned  lat;
  logic [7:0]   c6 = 8'hC6;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus_a.rx_valid) begin
      got_a.push_back(bus_a.rx_data);
      got_t_a.push_back(cyc);
    end
    if (bus_b.rx_valid) begin
      got_b.push_back(bus_b.rx_data);
      got_t_b.push_back(cyc);
    end
    if (bus_a.frame_err) fe_a++;
    if (bus_b.frame_err) fe_b++;
    if (bus_a.busy) busy_cnt_a++;
    if ((bus_a.rx_valid && bus_a.frame_err) || (bus_b.rx_valid && bus_b.frame_err)) overlap++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive one line level for n clocks. Changes land 1 ns after a rising edge.
  task automatic drive_bit(input bit sel, input logic v, input int n);
    if (sel) bus_b.rx = v;
    else     bus_a.rx = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input bit sel, input logic [7:0] data, input int bps,
                            input logic stop_bit, output int unsigned start_cyc);
    start_cyc = cyc;
    drive_bit(sel, 1'b0, bps);
    for (int i = 0; i < W; i++) drive_bit(sel, data[i], bps);
    drive_bit(sel, stop_bit, bps);
  endtask

  // Compare bytes received on instance A against the expected queue, then clear both.
  task automatic score(input string tag);
    check({tag, "_count"}, got_a.size(), exp_q.size());
    while (exp_q.size() > 0 && got_a.size() > 0)
      check({tag, "_data"}, got_a.pop_front(), exp_q.pop_front());
    exp_q.delete();
    got_a.delete();
    got_t_a.delete();
  endtask

  initial begin
    int unsigned ta, tb2, tc;
    bus_a.rx = 1'b1;
    bus_b.rx = 1'b1;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    check("rst_data",  bus_a.rx_data,   8'h00);
    check("rst_valid", bus_a.rx_valid,  1'b0);
    check("rst_ferr",  bus_a.frame_err, 1'b0);
    check("rst_busy",  bus_a.busy,      1'b0);
    check("rst_state", bus_a.state,     2'd0);
    rst = 1'b0;
    drive_bit(0, 1'b1, 20);

    // Good frame 0x55 and its latency.
    fe_a = 0;
    exp_q.push_back(8'h55);
    send_frame(0, 8'h55, BPS, 1'b1, t0);
    drive_bit(0, 1'b1, 2 * BPS);
    lat = (got_t_a.size() > 0) ? got_t_a[0] - t0 : 0;
    check("t1_latency_155_157", (lat >= 155 && lat <= 157), 1'b1);
    check("t1_ferr", fe_a, 0);
    score("t1");

    // Back-to-back frames with no idle gap.
    exp_q.push_back(8'hA3);
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    send_frame(0, 8'hA3, BPS, 1'b1, ta);
    send_frame(0, 8'h00, BPS, 1'b1, tb2);
    send_frame(0, 8'hFF, BPS, 1'b1, tc);
    drive_bit(0, 1'b1, 2 * BPS);
    check("t2_gap1", (got_t_a.size() >= 3) ? got_t_a[1] - got_t_a[0] : 0, 160);
    check("t2_gap2", (got_t_a.size() >= 3) ? got_t_a[2] - got_t_a[1] : 0, 160);
    check("t2_ferr", fe_a, 0);
    score("t2");

    // Glitch rejection: a 5-cycle low pulse.
    busy_cnt_a = 0;
    drive_bit(0, 1'b0, 5);
    drive_bit(0, 1'b1, 40);
    check("t3_busy_cycles", busy_cnt_a, 8);
    check("t3_ferr", fe_a, 0);
    score("t3");

    // Framing error followed by a held-low break, then recovery.
    send_frame(0, 8'h3C, BPS, 1'b0, t0);
    drive_bit(0, 1'b0, 50 * BPS);
    check("t4_ferr_once", fe_a, 1);
    check("t4_hold_data", bus_a.rx_data, 8'hFF);
    score("t4a");
    drive_bit(0, 1'b1, 3 * BPS);
    exp_q.push_back(8'h81);
    send_frame(0, 8'h81, BPS, 1'b1, t0);
    drive_bit(0, 1'b1, 2 * BPS);
    check("t4_ferr_after", fe_a, 1);
    score("t4b");

    // Asynchronous reset during bit 4 of 0xC6.
    fe_a = 0;
    drive_bit(0, 1'b0, BPS);
    for (int i = 0; i < 4; i++) drive_bit(0, c6[i], BPS);
    bus_a.rx = c6[4];
    repeat (5) @(posedge clk);
    #1;
    check("t5_busy_before", bus_a.busy, 1'b1);
    check("t5_data_before", bus_a.rx_data, 8'h81);
    #3 rst = 1'b1;
    #1;
    check("t5_rst_data",  bus_a.rx_data,   8'h00);
    check("t5_rst_valid", bus_a.rx_valid,  1'b0);
    check("t5_rst_ferr",  bus_a.frame_err, 1'b0);
    check("t5_rst_busy",  bus_a.busy,      1'b0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("t5_no_pulse", got_a.size() + fe_a, 0);
    drive_bit(0, c6[4], BPS - 8);
    for (int i = 5; i < W; i++) drive_bit(0, c6[i], BPS);
    drive_bit(0, 1'b1, 20 * BPS);
    got_a.delete();
    got_t_a.delete();
    fe_a = 0;
    exp_q.push_back(8'h5A);
    send_frame(0, 8'h5A, BPS, 1'b1, t0);
    drive_bit(0, 1'b1, 2 * BPS);
    check("t5_ferr", fe_a, 0);
    score("t5");

    // Default divisor: 0x7E at 5208 clk/bit on instance B.
    fe_b = 0;
    send_frame(1, 8'h7E, BPS_D, 1'b1, t0);
    drive_bit(1, 1'b1, BPS_D);
    lat = (got_t_b.size() > 0) ? got_t_b[0] - t0 : 0;
    check("t6_count", got_b.size(), 1);
    check("t6_data", (got_b.size() > 0) ? got_b[0] : 8'h00, 8'h7E);
    check("t6_latency_49479_49481", (lat >= 49479 && lat <= 49481), 1'b1);
    check("t6_ferr", fe_b, 0);

    check("valid_ferr_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
